// File: rtl/led_mode_switcher.sv
// rtl/led_mode_switcher.sv - LED pattern mode selector with blanked mode changes and auto-cycle
module led_mode_switcher #(
    parameter int LED_WIDTH    = 8,
    parameter int NUM_MODES    = 4,
    parameter int MODE_W       = $clog2(NUM_MODES + 1),
    parameter int BLANK_CYCLES = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_MODES*LED_WIDTH-1:0] mode_patterns,
    input  logic [MODE_W-1:0]              mode_select,
    input  logic                           auto_en,
    output logic [LED_WIDTH-1:0]           signal,
    output logic [MODE_W-1:0]              active_mode,
    output logic                           busy,
    output logic                           mode_changed
);

    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [BW-1:0] BLANK_LOAD = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [LED_WIDTH-1:0] OFF = {LED_WIDTH{ACTIVE_LOW != 0}};

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t          state;
    logic [MODE_W-1:0] pending;
    logic [MODE_W-1:0] auto_mode;
    logic [BW-1:0]   blank_cnt;
    logic [DW-1:0]   dwell_cnt;
    logic            auto_en_q;

    logic            auto_rise;
    logic            dwell_wrap;
    logic [MODE_W-1:0] auto_next;
    logic [MODE_W-1:0] auto_tgt;
    logic [MODE_W-1:0] manual_tgt;
    logic [MODE_W-1:0] target;

    function automatic logic [LED_WIDTH-1:0] drive_of(
        input logic [MODE_W-1:0]              m,
        input logic [NUM_MODES*LED_WIDTH-1:0] pats
    );
        logic [LED_WIDTH-1:0] on;
        on = '0;
        for (int k = 1; k <= NUM_MODES; k++) begin
            if (m == MODE_W'(k)) on = pats[(k-1)*LED_WIDTH +: LED_WIDTH];
        end
        return (ACTIVE_LOW != 0) ? ~on : on;
    endfunction

    // The advanced auto mode is visible in the wrap cycle itself, so the blank
    // starts on that edge and each mode is on display for exactly DWELL_CYCLES.
    always_comb begin
        auto_rise  = auto_en & ~auto_en_q;
        dwell_wrap = auto_en & ~auto_rise & (state == SHOW) & (dwell_cnt == DWELL_LAST);
        auto_next  = (auto_mode == MODE_W'(NUM_MODES)) ? MODE_W'(1) : auto_mode + MODE_W'(1);
        auto_tgt   = auto_rise ? MODE_W'(1) : (dwell_wrap ? auto_next : auto_mode);
        manual_tgt = (mode_select != '0 && mode_select <= MODE_W'(NUM_MODES)) ? mode_select : '0;
        target     = auto_en ? auto_tgt : manual_tgt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            signal       <= OFF;
            active_mode  <= '0;
            busy         <= 1'b0;
            mode_changed <= 1'b0;
            pending      <= '0;
            blank_cnt    <= '0;
            auto_mode    <= MODE_W'(1);
            dwell_cnt    <= '0;
            auto_en_q    <= 1'b0;
        end else begin
            auto_en_q    <= auto_en;
            mode_changed <= 1'b0;

            if (!auto_en) begin
                dwell_cnt <= '0;
            end else if (auto_rise) begin
                auto_mode <= MODE_W'(1);
                dwell_cnt <= '0;
            end else if (state == SHOW) begin
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_cnt <= '0;
                    auto_mode <= auto_next;
                end else begin
                    dwell_cnt <= dwell_cnt + DW'(1);
                end
            end

            case (state)
                IDLE, SHOW: begin
                    if (target != active_mode) begin
                        if (BLANK_CYCLES > 0) begin
                            state     <= BLANK;
                            pending   <= target;
                            blank_cnt <= BLANK_LOAD;
                            busy      <= 1'b1;
                            signal    <= OFF;
                        end else begin
                            active_mode  <= target;
                            mode_changed <= 1'b1;
                            signal       <= drive_of(target, mode_patterns);
                            state        <= (target != '0) ? SHOW : IDLE;
                        end
                    end else begin
                        signal <= drive_of(active_mode, mode_patterns);
                    end
                end
                BLANK: begin
                    signal <= OFF;
                    if (target != pending) begin
                        pending   <= target;
                        blank_cnt <= BLANK_LOAD;
                    end else if (blank_cnt == '0) begin
                        active_mode  <= pending;
                        mode_changed <= 1'b1;
                        busy         <= 1'b0;
                        signal       <= drive_of(pending, mode_patterns);
                        state        <= (pending != '0) ? SHOW : IDLE;
                    end else begin
                        blank_cnt <= blank_cnt - BW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    signal <= OFF;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_mode_switcher.sv
// tb/tb_led_mode_switcher.sv - self-checking bench for led_mode_switcher
module tb_led_mode_switcher;

    localparam int LW    = 8;
    localparam int NM    = 4;
    localparam int MW    = $clog2(NM + 1);
    localparam int BLANK = 4;
    localparam int DWELL = 16;

    logic            clk;
    logic            rst_n;
    logic [NM*LW-1:0] mode_patterns;
    logic [MW-1:0]   mode_select;
    logic            auto_en;
    logic [LW-1:0]   signal;
    logic [MW-1:0]   active_mode;
    logic            busy;
    logic            mode_changed;

    logic [LW-1:0]   drv [1:NM];
    assign mode_patterns = {drv[4], drv[3], drv[2], drv[1]};

    led_mode_switcher #(
        .LED_WIDTH(LW), .NUM_MODES(NM), .BLANK_CYCLES(BLANK),
        .DWELL_CYCLES(DWELL), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode_patterns(mode_patterns),
        .mode_select(mode_select), .auto_en(auto_en), .signal(signal),
        .active_mode(active_mode), .busy(busy), .mode_changed(mode_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: displayed mode, how many OFF cycles remain, and how long
    // the current auto mode has been on display.
    int         m_mode, m_pend, m_left, m_shown, m_auto;
    bit         m_blank, m_prev_auto, model_valid;
    logic [LW-1:0] exp_sig;
    bit         exp_chg;

    initial model_valid = 0;

    always @(posedge clk) begin
        int tgt;
        bit rise;
        if (!rst_n) begin
            m_mode = 0; m_pend = 0; m_left = 0; m_blank = 0;
            m_auto = 1; m_shown = 0; m_prev_auto = 0; exp_chg = 0;
        end else begin
            rise = auto_en && !m_prev_auto;
            if (!auto_en) m_shown = 0;
            else if (rise) begin m_auto = 1; m_shown = 0; end
            else if (!m_blank && m_mode != 0) begin
                m_shown++;
                if (m_shown == DWELL) begin m_shown = 0; m_auto = m_auto % NM + 1; end
            end
            tgt = auto_en ? m_auto : ((mode_select >= 1 && mode_select <= NM) ? int'(mode_select) : 0);
            exp_chg = 0;
            if (m_blank) begin
                if (tgt != m_pend) begin
                    m_pend = tgt; m_left = BLANK;
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_mode = m_pend; m_blank = 0; exp_chg = 1; end
                end
            end else if (tgt != m_mode) begin
                m_blank = 1; m_pend = tgt; m_left = BLANK;
            end
            m_prev_auto = auto_en;
        end
        exp_sig = (m_blank || m_mode == 0) ? 8'hFF : ~drv[m_mode];
        model_valid = 1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("signal", signal, exp_sig);
            check("active_mode", active_mode, m_mode);
            check("busy", busy, m_blank);
            check("mode_changed", mode_changed, exp_chg);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int pulses, off, saw3, n;
    int seq [5];
    int tim [5];

    initial begin
        rst_n = 0; mode_select = 0; auto_en = 0;
        drv[1] = 8'h0F; drv[2] = 8'h3C; drv[3] = 8'hA5; drv[4] = 8'hF0;

        // reset then idle
        tick(2);
        check("rst_signal", signal, 8'hFF);
        check("rst_mode", active_mode, 0);
        check("rst_busy", busy, 0);
        rst_n = 1;
        pulses = 0;
        repeat (5) begin tick(1); pulses += mode_changed; end
        check("idle_no_pulse", pulses, 0);
        check("idle_signal", signal, 8'hFF);

        // manual select of mode 2
        mode_select = 2;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("m2_blank_signal", signal, 8'hFF);
            check("m2_blank_busy", busy, 1);
        end
        tick(1);
        check("m2_changed", mode_changed, 1);
        check("m2_mode", active_mode, 2);
        check("m2_signal", signal, 8'hC3);
        drv[2] = 8'h81;
        tick(1);
        check("m2_follow", signal, 8'h7E);

        // retarget mid-blank
        mode_select = 1;
        tick(6);
        check("rt_start_mode", active_mode, 1);
        mode_select = 3;
        tick(1);
        check("rt_first_busy", busy, 1);
        mode_select = 4;
        off = 1; pulses = 0; saw3 = 0;
        repeat (8) begin
            tick(1);
            off += busy;
            pulses += mode_changed;
            if (active_mode == 3) saw3 = 1;
        end
        check("rt_off_cycles", off, 5);
        check("rt_pulses", pulses, 1);
        check("rt_mode", active_mode, 4);
        check("rt_no_mode3", saw3, 0);

        // invalid select goes to off
        mode_select = 1;
        tick(8);
        check("inv_start_mode", active_mode, 1);
        mode_select = 7;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("inv_busy", busy, 1);
        end
        tick(1);
        check("inv_changed", mode_changed, 1);
        check("inv_mode", active_mode, 0);
        check("inv_signal", signal, 8'hFF);
        tick(2);
        check("inv_idle_busy", busy, 0);
        check("inv_idle_mode", active_mode, 0);

        // auto-cycle from off, manual select ignored
        auto_en = 1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            mode_select = MW'($urandom_range(0, 7));
            tick(1);
            if (mode_changed) begin
                if (n < 5) begin seq[n] = active_mode; tim[n] = i; end
                n++;
            end
        end
        check("auto_pulses", n, 5);
        for (int k = 0; k < 5; k++) check("auto_seq", seq[k], (k % NM) + 1);
        for (int k = 0; k < 4; k++) check("auto_period", tim[k+1] - tim[k], DWELL + BLANK);
        check("auto_first", tim[0], BLANK);
        auto_en = 0; mode_select = 0;
        tick(12);
        check("auto_off_mode", active_mode, 0);

        // reset mid-blank
        mode_select = 3;
        tick(2);
        check("rb_busy", busy, 1);
        rst_n = 0;
        tick(1);
        check("rb_signal", signal, 8'hFF);
        check("rb_mode", active_mode, 0);
        check("rb_busy0", busy, 0);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("rb_reblank", busy, 1);
            check("rb_reblank_sig", signal, 8'hFF);
        end
        tick(1);
        check("rb_mode3", active_mode, 3);
        check("rb_sig3", signal, 8'h5A);
        check("rb_changed", mode_changed, 1);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            for (int k = 1; k <= NM; k++) drv[k] = LW'($urandom);
            if ($urandom_range(0, 29) == 0) mode_select = MW'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
            rst_n = ($urandom_range(0, 499) != 0);
            tick(1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/led_mode_switcher.md
Name: led_mode_switcher

Overview:
- Parametrised LED pattern mode selector.
- Multiplexes NUM_MODES pattern-driver buses of LED_WIDTH bits onto one registered LED output.
- Every mode change is glitch-free: the LEDs are blanked for BLANK_CYCLES before the new pattern appears.
- Optional auto-cycle steps through modes 1..NUM_MODES every DWELL_CYCLES. Sits between the per-mode LED drivers and the board LED pins.

Parameters:
- LED_WIDTH, 8, number of LEDs per pattern bus and output.
- NUM_MODES, 4, number of pattern-driver inputs (>=1).
- MODE_W, $clog2(NUM_MODES+1), width of mode codes (derived; 0 = off).
- BLANK_CYCLES, 4, blank interval on mode change (0 = switch immediately).
- DWELL_CYCLES, 50_000_000, cycles per mode in auto-cycle (>=1).
- ACTIVE_LOW, 1, 1: output inverted, LED off = all ones; 0: off = all zeros.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- mode_patterns  in  NUM_MODES*LED_WIDTH  driver k (1-based) at bits [k*LED_WIDTH-1 : (k-1)*LED_WIDTH]; active-high LED on.
- mode_select  in  MODE_W  manual mode; 0 or >NUM_MODES = off.
- auto_en  in  1  1 = auto-cycle, mode_select ignored.
- signal  out  LED_WIDTH  registered LED drive, polarity per ACTIVE_LOW.
- active_mode  out  MODE_W  mode currently displayed (0 = off).
- busy  out  1  high while blanking.
- mode_changed  out  1  one-cycle pulse in the cycle active_mode updates.

Behaviour:
- Reset (rst_n low at clk edge):
  - signal = OFF, where OFF = ACTIVE_LOW ? all ones : all zeros.
  - active_mode=0, busy=0, mode_changed=0.
  - auto_mode=1, dwell counter=0, state=IDLE.
  - Applies mid-blank or mid-show with no residual pending mode.
- Target mode: auto_en ? auto_mode : (mode_select in 1..NUM_MODES ? mode_select : 0). Combinational, sampled every cycle.
- States:
  - IDLE: active_mode=0, signal=OFF.
  - SHOW: signal = pattern of active_mode, polarity-adjusted, registered, 1-cycle latency from mode_patterns.
  - BLANK: signal=OFF, busy=1.
- Transitions from IDLE/SHOW when target != active_mode:
  - BLANK_CYCLES>0: go to BLANK, pending=target, blank counter=BLANK_CYCLES-1, busy=1 next cycle. signal is OFF from the next cycle.
  - BLANK_CYCLES=0: active_mode=target directly, mode_changed=1, new pattern on signal the same cycle active_mode updates.
- BLANK behaviour:
  - If target != pending: pending=target, counter reloads to BLANK_CYCLES-1 (restart).
  - Else, at counter==0: active_mode=pending, mode_changed=1, busy=0. Next state is SHOW if pending!=0, else IDLE.
  - Else decrement.
  - Total blank with stable target = exactly BLANK_CYCLES cycles of OFF.
  - Target returning to the old active_mode during BLANK still completes the blank (no abort).
- Auto-cycle:
  - The dwell counter increments only when auto_en=1 and state=SHOW.
  - At DWELL_CYCLES-1: counter=0, auto_mode increments, wrapping NUM_MODES->1.
  - auto_en=0: dwell counter held at 0, auto_mode held.
  - Rising edge of auto_en: auto_mode reloaded to 1, dwell=0.
  - Dwell does not advance during BLANK, so each mode displays for exactly DWELL_CYCLES.
- Arithmetic: all counters unsigned, width $clog2(max+1), no overflow past terminal value.
- NUM_MODES=1: auto-cycle holds mode 1, and no change is triggered.

Test Plan:
(defaults LED_WIDTH=8, NUM_MODES=4, BLANK_CYCLES=4, ACTIVE_LOW=1; DWELL_CYCLES=16 for bench)
- Reset then idle: rst_n=0 two cycles, mode_select=0 -> signal=8'hFF, active_mode=0, busy=0, mode_changed never pulses.
- Manual select: driver2 bus=8'h3C, mode_select 0->2 -> 4 cycles signal=8'hFF with busy=1, then mode_changed pulse, active_mode=2, signal=8'hC3. Driver2 changing to 8'h81 appears as 8'h7E one cycle later.
- Retarget mid-blank: mode_select 1->3, then ->4 in the 2nd blank cycle -> blank restarts, 5 total OFF cycles, active_mode goes straight to 4, single mode_changed pulse, mode 3 never shown.
- Auto-cycle wrap: auto_en=1 from active_mode=0 -> 4-cycle blank, then modes 1,2,3,4,1 each shown 16 cycles, separated by 4-cycle blanks; mode_select changes ignored.
- Invalid/off select: mode_select=7 while showing mode 1 -> 4-cycle blank, then active_mode=0, state IDLE, signal=8'hFF.
- Reset mid-blank: rst_n=0 in 2nd blank cycle of 0->3 change -> next cycle signal=8'hFF, active_mode=0, busy=0. After release with mode_select=3, a full fresh 4-cycle blank precedes mode 3.
